// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array sharing one decay/fire datapath.
// Optional per-neuron refractory counters are enabled by defining LIF_REFRACTORY_EN.
//
//   state | meaning
//   IDLE  | accepting accumulate/timestep commands
//   STEP  | decay-and-fire sweep, neuron k_q processed this cycle
module lif_neuron_array #(
   parameter int N_NEURONS    = 16,
   parameter int IDX_W        = 4,
   parameter int WEIGHT_W     = 8,
   parameter int VMEM_W       = 9,
   parameter int BETA_W       = 8,
   parameter int RESET_MODE   = 0,
   parameter int REFRAC_STEPS = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_op,
   input  logic [IDX_W-1:0]           cmd_idx,
   input  logic signed [WEIGHT_W-1:0] cmd_weight,
   input  logic [BETA_W-1:0]          beta,
   input  logic [VMEM_W-2:0]          v_th,
   output logic                       out_valid,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_spike,
   output logic                       out_last
);

   localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
   localparam int DW = VMEM_W + 1;
   localparam int PW = VMEM_W + BETA_W + 1;
   localparam logic signed [VMEM_W-1:0] VMAX = {1'b0, {(VMEM_W-1){1'b1}}};
   localparam logic signed [VMEM_W-1:0] VMIN = {1'b1, {(VMEM_W-1){1'b0}}};

   typedef enum logic [0:0] {IDLE, STEP} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          k_q, k_d;
   logic [BETA_W-1:0]         beta_q, beta_d;
   logic [VMEM_W-2:0]         vth_q, vth_d;
   logic signed [VMEM_W-1:0]  vmem_q [N_NEURONS];
   logic                      out_valid_q, out_valid_d;
   logic [IDX_W-1:0]          out_idx_q, out_idx_d;
   logic                      out_spike_q, out_spike_d;
   logic                      out_last_q, out_last_d;

   logic [IDX_W-1:0]          rd_idx;
   logic                      rd_ok;
   logic signed [VMEM_W-1:0]  v_cur;
   logic                      refr_busy;
   logic                      accept;
   logic                      last_k;
   logic signed [DW-1:0]      sum;
   logic signed [VMEM_W-1:0]  sum_sat;
   logic signed [PW-1:0]      prod;
   logic signed [VMEM_W-1:0]  dec;
   logic signed [DW-1:0]      diff;
   logic                      spike;
   logic                      wr_en;
   logic signed [VMEM_W-1:0]  wr_data;

   assign cmd_ready = (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign last_k    = (int'(k_q) == N_NEURONS - 1);

   // Single read port: the sweep index in STEP, the command index otherwise.
   always_comb begin
      rd_idx = (state_q == STEP) ? k_q : cmd_idx;
      rd_ok  = (int'(rd_idx) < N_NEURONS);
      v_cur  = rd_ok ? vmem_q[rd_idx[IW-1:0]] : '0;
   end

   always_comb begin
      sum = DW'(v_cur) + DW'(cmd_weight);
      if (sum[DW-1] != sum[DW-2]) sum_sat = sum[DW-1] ? VMIN : VMAX;
      else                        sum_sat = sum[VMEM_W-1:0];
      prod  = PW'(v_cur) * $signed(PW'({1'b0, beta_q}));
      dec   = VMEM_W'(prod >>> BETA_W);
      diff  = DW'(dec) - $signed(DW'({1'b0, vth_q}));
      spike = !diff[DW-1] && !refr_busy;
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      beta_d      = beta_q;
      vth_d       = vth_q;
      wr_en       = 1'b0;
      wr_data     = '0;
      out_valid_d = 1'b0;
      out_idx_d   = '0;
      out_spike_d = 1'b0;
      out_last_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_op) begin
                  beta_d  = beta;
                  vth_d   = v_th;
                  k_d     = '0;
                  state_d = STEP;
               end else if (rd_ok && !refr_busy) begin
                  wr_en   = 1'b1;
                  wr_data = sum_sat;
               end
            end
         end
         STEP: begin
            wr_en       = 1'b1;
            out_valid_d = 1'b1;
            out_idx_d   = k_q;
            out_spike_d = spike;
            out_last_d  = last_k;
            if (refr_busy)  wr_data = '0;
            else if (spike) wr_data = (RESET_MODE == 1) ? VMEM_W'(diff) : '0;
            else            wr_data = dec;
            if (last_k) begin
               state_d = IDLE;
               k_d     = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         beta_q      <= '0;
         vth_q       <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         out_spike_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         beta_q      <= beta_d;
         vth_q       <= vth_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         out_spike_q <= out_spike_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) vmem_q[i] <= '0;
      end else if (wr_en) begin
         vmem_q[rd_idx[IW-1:0]] <= wr_data;
      end
   end

`ifdef LIF_REFRACTORY_EN
   localparam int RW = (REFRAC_STEPS > 1) ? $clog2(REFRAC_STEPS + 1) : 1;
   logic [RW-1:0] refr_q [N_NEURONS];

   assign refr_busy = rd_ok && (refr_q[rd_idx[IW-1:0]] != '0);

   // Counters only move during a sweep; accumulates merely consult them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
      end else if (state_q == STEP) begin
         if (refr_busy)  refr_q[rd_idx[IW-1:0]] <= refr_q[rd_idx[IW-1:0]] - RW'(1);
         else if (spike) refr_q[rd_idx[IW-1:0]] <= RW'(REFRAC_STEPS);
      end
   end
`else
   assign refr_busy = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign out_spike = out_spike_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: two instances (reset-to-zero and reset-by-subtraction)
// share one command bus; a behavioural model queues expected results per instance.
module tb_lif_neuron_array;
   localparam int N = 16, IDX_W = 5, WW = 8, VW = 9, BW = 8, RS = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid, cmd_op;
   logic [IDX_W-1:0] cmd_idx;
   logic signed [WW-1:0] cmd_weight;
   logic [BW-1:0] beta;
   logic [VW-2:0] v_th;
   logic rdy [2];
   logic ov [2];
   logic osp [2];
   logic olast [2];
   logic [IDX_W-1:0] oidx [2];

   always #5 clk = ~clk;

   lif_neuron_array #(.N_NEURONS(N), .IDX_W(IDX_W), .WEIGHT_W(WW), .VMEM_W(VW), .BETA_W(BW),
                      .RESET_MODE(0), .REFRAC_STEPS(RS)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .cmd_op(cmd_op),
      .cmd_idx(cmd_idx), .cmd_weight(cmd_weight), .beta(beta), .v_th(v_th),
      .out_valid(ov[0]), .out_idx(oidx[0]), .out_spike(osp[0]), .out_last(olast[0]));

   lif_neuron_array #(.N_NEURONS(N), .IDX_W(IDX_W), .WEIGHT_W(WW), .VMEM_W(VW), .BETA_W(BW),
                      .RESET_MODE(1), .REFRAC_STEPS(RS)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .cmd_op(cmd_op),
      .cmd_idx(cmd_idx), .cmd_weight(cmd_weight), .beta(beta), .v_th(v_th),
      .out_valid(ov[1]), .out_idx(oidx[1]), .out_spike(osp[1]), .out_last(olast[1]));

   typedef struct {int idx; int spike; int last;} exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int mv [2][N];
   int mr [2][N];
   int tests = 0;
   int fails = 0;

   task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int sat(int v);
      if (v > 255)  return 255;
      if (v < -256) return -256;
      return v;
   endfunction

   function automatic bit refr_on(int d, int i);
`ifdef LIF_REFRACTORY_EN
      return mr[d][i] > 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_acc(int idx, int w);
      for (int d = 0; d < 2; d++)
         if (idx < N && !refr_on(d, idx)) mv[d][idx] = sat(mv[d][idx] + w);
   endtask

   task automatic model_step(int b, int th);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < N; k++) begin
            int dec, diff, sp;
            exp_t e;
            sp = 0;
            if (refr_on(d, k)) begin
               mr[d][k]--;
               mv[d][k] = 0;
            end else begin
               dec  = (mv[d][k] * b) >>> BW;
               diff = dec - th;
               sp   = (diff >= 0) ? 1 : 0;
               if (sp == 1) begin
                  mv[d][k] = (d == 1) ? diff : 0;
                  mr[d][k] = RS;
               end else begin
                  mv[d][k] = dec;
               end
            end
            e = '{k, sp, (k == N - 1) ? 1 : 0};
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < N; k++) begin
            mv[d][k] = 0;
            mr[d][k] = 0;
         end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_out(int d);
      exp_t e;
      int have;
      if (d == 0) begin
         have = q0.size();
         if (have > 0) e = q0.pop_front();
      end else begin
         have = q1.size();
         if (have > 0) e = q1.pop_front();
      end
      if (have == 0) begin
         chk($sformatf("unexpected_out_valid_d%0d", d), 1, 0);
      end else begin
         chk($sformatf("out_idx_d%0d", d), oidx[d], e.idx);
         chk($sformatf("out_spike_d%0d_n%0d", d, e.idx), osp[d], e.spike);
         chk($sformatf("out_last_d%0d_n%0d", d, e.idx), olast[d], e.last);
         if (e.last == 1) chk($sformatf("ready_at_last_d%0d", d), rdy[d], 1);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (ov[0]) check_out(0);
         if (ov[1]) check_out(1);
      end
   end

   task automatic do_acc(int idx, int w);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_op     = 1'b0;
      cmd_idx    = idx[IDX_W-1:0];
      cmd_weight = w[WW-1:0];
      chk("acc_ready", rdy[0], 1);
      @(posedge clk);
      model_acc(idx, w);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Commands offered while busy (weight to neuron 9) must be ignored.
   task automatic do_step(int b, int th);
      int cnt;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      beta      = b[BW-1:0];
      v_th      = th[VW-2:0];
      chk("step_ready", rdy[0], 1);
      @(posedge clk);
      model_step(b, th);
      cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rdy[0]) break;
         cnt++;
         cmd_op     = 1'b0;
         cmd_idx    = 5'd9;
         cmd_weight = 8'sd100;
      end
      cmd_valid = 1'b0;
      chk("step_busy_cycles", cnt, N);
      chk("step_ready_d1", rdy[1], 1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_idx = '0; cmd_weight = '0; beta = '0; v_th = '0;
      clear_model();
      #12;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ready_d%0d", d), rdy[d], 1);
         chk($sformatf("rst_valid_d%0d", d), ov[d], 0);
         chk($sformatf("rst_idx_d%0d", d), oidx[d], 0);
         chk($sformatf("rst_spike_d%0d", d), osp[d], 0);
         chk($sformatf("rst_last_d%0d", d), olast[d], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      do_step(8'h80, 10);

      do_acc(3, 100);
      do_acc(3, 100);
      do_step(255, 100);
      do_step(255, 100);

      for (int i = 0; i < 3; i++) do_acc(0, 127);
      for (int i = 0; i < 3; i++) do_acc(1, -128);
      for (int i = 0; i < 3; i++) do_acc(20, 127);
      do_step(255, 253);

      do_acc(2, -3);
      do_step(128, 0);
      do_acc(2, 1);
      do_step(255, 0);

      do_acc(5, 100);
      do_acc(5, 100);
      do_step(255, 50);
      do_acc(5, 100);
      do_step(255, 50);
      do_step(255, 50);
      do_step(255, 50);

      do_acc(7, 100);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 1'b1;
      beta      = 8'd255;
      v_th      = 8'd1;
      @(posedge clk);
      model_step(255, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrst_valid_d%0d", d), ov[d], 0);
         chk($sformatf("midrst_idx_d%0d", d), oidx[d], 0);
         chk($sformatf("midrst_spike_d%0d", d), osp[d], 0);
         chk($sformatf("midrst_last_d%0d", d), olast[d], 0);
         chk($sformatf("midrst_ready_d%0d", d), rdy[d], 1);
      end
      clear_model();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_quiet_d0", ov[0], 0);
      chk("post_rst_quiet_d1", ov[1], 0);
      do_step(255, 1);

      repeat (3) @(negedge clk);
      chk("pending_d0", q0.size(), 0);
      chk("pending_d1", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
